// File: rtl/mips_ctl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM states,
// ALU_op / ALUSrcB / PCSource codes and the bundled control-output struct.
package mips_ctl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctl_t;

endpackage

// File: rtl/mc_ctl_outdec.sv
// Combinational state -> datapath control decode for the multicycle control.
// ADDI states decode only when MC_CTL_ADDI_EN is defined.
module mc_ctl_outdec
    import mips_ctl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctl_t       ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_4;
                ctl.alu_op    = ALU_ADD;
                // IR and PC only latch once memory has actually returned the word
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = ALU_ADD;
            end
`ifdef MC_CTL_ADDI_EN
            S_MEMADR, S_ADDI_EX: begin
`else
            S_MEMADR: begin
`endif
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
`ifdef MC_CTL_ADDI_EN
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
            end
`endif
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and reset
// gating of outputs. Define MC_CTL_ADDI_EN to compile in the ADDI path.
module mips_mc_control
    import mips_ctl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           IRWrite,
    output logic           ALUSrcA,
    output logic           RegWrite,
    output logic           RegDst,
    output logic [1:0]     ALU_op,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSource,
    output logic           illegal_op,
    output logic [3:0]     state
);

    state_t state_q;
    state_t state_d;
    logic   illegal;
    ctl_t   ctl;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
`ifdef MC_CTL_ADDI_EN
            S_ADDI_EX: state_d = S_ADDI_WB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctl       (ctl)
    );

    // Outputs are held at zero for as long as reset_n is low, even mid-instruction
    assign PCWrite     = reset_n & ctl.pc_write;
    assign PCWriteCond = reset_n & ctl.pc_write_cond;
    assign IorD        = reset_n & ctl.i_or_d;
    assign MemRead     = reset_n & ctl.mem_read;
    assign MemWrite    = reset_n & ctl.mem_write;
    assign MemtoReg    = reset_n & ctl.mem_to_reg;
    assign IRWrite     = reset_n & ctl.ir_write;
    assign ALUSrcA     = reset_n & ctl.alu_src_a;
    assign RegWrite    = reset_n & ctl.reg_write;
    assign RegDst      = reset_n & ctl.reg_dst;
    assign ALU_op      = reset_n ? ctl.alu_op    : 2'b00;
    assign ALUSrcB     = reset_n ? ctl.alu_src_b : 2'b00;
    assign PCSource    = reset_n ? ctl.pc_source : 2'b00;
    assign illegal_op  = reset_n & illegal;
    assign state       = reset_n ? 4'(state_q) : 4'd0;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-instruction cycle sequences are
// expanded from the instruction class and stall counts, checked every cycle.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [1:0] ALU_op, ALUSrcB, PCSource;
    logic [3:0] state;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef MC_CTL_ADDI_EN
    localparam bit ADDI_ON = 1'b1;
`else
    localparam bit ADDI_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    mips_mc_control #(.OPW(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALU_op      (ALU_op),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    // Expected control word for a given step: {PCWrite,PCWriteCond,IorD,MemRead,
    // MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,ALU_op,ALUSrcB,PCSource,illegal}
    function automatic logic [18:0] exp_vec(input int st, input bit mr, input bit ill);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
        logic irw = 0, srca = 0, rw = 0, rd = 0;
        logic [1:0] aop = 0, srcb = 0, pcs = 0;
        case (st)
            0:  begin mrd = 1; srcb = 2'd1; irw = mr; pcw = mr; end
            1:  srcb = 2'd3;
            2, 10: begin srca = 1; srcb = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'd2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin srca = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
            9:  begin pcw = 1; pcs = 2'd2; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, aop, srcb, pcs, ill};
    endfunction

    task automatic cyc(input int st, input bit mr, input bit ill, input bit rst);
        exp_t e;
        reset_n   = rst;
        mem_ready = mr;
        e.st = rst ? 4'(st) : 4'd0;
        e.v  = rst ? exp_vec(st, mr, ill) : 19'd0;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: sf FETCH stalls, sm stalls in the memory-access step
    task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
        opcode = op;
        repeat (sf) cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        if (op == 6'b100011) begin
            cyc(1, rbit(), 0, 1);
            cyc(2, rbit(), 0, 1);
            repeat (sm) cyc(3, 0, 0, 1);
            cyc(3, 1, 0, 1);
            cyc(4, rbit(), 0, 1);
        end else if (op == 6'b101011) begin
            cyc(1, rbit(), 0, 1);
            cyc(2, rbit(), 0, 1);
            repeat (sm) cyc(5, 0, 0, 1);
            cyc(5, 1, 0, 1);
        end else if (op == 6'b000000) begin
            cyc(1, rbit(), 0, 1);
            cyc(6, rbit(), 0, 1);
            cyc(7, rbit(), 0, 1);
        end else if (op == 6'b000100) begin
            cyc(1, rbit(), 0, 1);
            cyc(8, rbit(), 0, 1);
        end else if (op == 6'b000010) begin
            cyc(1, rbit(), 0, 1);
            cyc(9, rbit(), 0, 1);
        end else if (op == 6'b001000 && ADDI_ON) begin
            cyc(1, rbit(), 0, 1);
            cyc(10, rbit(), 0, 1);
            cyc(11, rbit(), 0, 1);
        end else begin
            cyc(1, rbit(), 1, 1);
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] r;
        case ($urandom_range(0, 6))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b000010;
            5: return 6'b001000;
            default: begin
                r = 6'($urandom);
                return r;
            end
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        logic [18:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                       IRWrite, ALUSrcA, RegWrite, RegDst, ALU_op, ALUSrcB,
                       PCSource, illegal_op};
                n_cmp++;
                if (state !== e.st) begin
                    n_bad++;
                    $display("FAIL state: got %0d want %0d at %0t", state, e.st, $time);
                end
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL ctl[st=%0d]: got %b want %b at %0t", e.st, act, e.v, $time);
                end
            end
        end
    end

    initial begin : stim
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        @(posedge clk);
        #1;
        repeat (3) cyc(0, 1, 0, 0);

        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 2);
        run_instr(6'b000000, 1, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001000, 0, 0);

        // reset arrives while a load is stalled in MEMRD
        opcode = 6'b100011;
        cyc(0, 1, 0, 1);
        cyc(1, rbit(), 0, 1);
        cyc(2, rbit(), 0, 1);
        cyc(3, 0, 0, 1);
        cyc(0, rbit(), 0, 0);

        for (int i = 0; i < 80; i++)
            run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3));

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
